// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty sequencer and the PWM datapath.
//   DUTY_W / DUTY_MAX / DUTY_INIT : duty value width, period length (= max duty), reset duty
//   DWELL_W                       : width of the per-command dwell count
//   FIFO_DEPTH                    : default command queue depth (power of two)
//   seq_state_t                   : sequencer FSM states
//   cmd_t                         : queued command {duty, dwell}
package pwm_pkg;

    localparam int DUTY_W     = 4;
    localparam int DWELL_W    = 8;
    localparam int FIFO_DEPTH = 4;

    localparam logic [DUTY_W-1:0] DUTY_MAX  = 4'd10;
    localparam logic [DUTY_W-1:0] DUTY_INIT = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RAMP  = 2'd2,
        DWELL = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [DUTY_W-1:0]  duty;
        logic [DWELL_W-1:0] dwell;
    } cmd_t;

    // Saturate a requested duty to the legal 0..DUTY_MAX range.
    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
        return (d > DUTY_MAX) ? DUTY_MAX : d;
    endfunction

endpackage

// File: rtl/pwm_cmd_fifo.sv
// Synchronous command FIFO for the duty sequencer.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : empties the queue (takes priority over push/pop)
//   push, wr_data : write an entry (ignored when full)
//   pop           : retire the head entry (ignored when empty)
//   rd_data       : current head entry (valid while !empty)
//   full, empty   : occupancy flags
module pwm_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Command-driven duty sequencer for the PWM comparator. Commands {duty, dwell}
// are queued; each is ramped to by +/-1 per PWM period boundary, held for
// `dwell` further boundaries, then retired with a done pulse.
//   clk, rst           : clock, synchronous active-high reset
//   cmd_valid/ready    : command handshake; cmd_duty, cmd_dwell carry the command
//   period_start       : one-cycle pulse at PWM counter wrap
//   abort              : flush queue and stop sequencing, duty held
//   duty_out           : duty value to the PWM comparator
//   busy, done         : activity flag, one-cycle retire pulse
//   clamp_err          : one-cycle pulse when a loaded duty exceeded DUTY_MAX
//
// state | meaning
// IDLE  | waiting for a queued command; pops the head when one is present
// LOAD  | latch clamped target and dwell count from the popped command
// RAMP  | step duty_out toward target at each period boundary
// DWELL | count down dwell periods at target, then retire
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int FIFO_DEPTH = pwm_pkg::FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [DUTY_W-1:0]  cmd_duty,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               period_start,
    input  logic               abort,
    output logic [DUTY_W-1:0]  duty_out,
    output logic               busy,
    output logic               done,
    output logic               clamp_err
);

    seq_state_t         state, state_nxt;
    cmd_t               cmd_reg, cmd_nxt;
    cmd_t               cmd_in;
    cmd_t               fifo_head;
    logic [DUTY_W-1:0]  target, target_nxt;
    logic [DUTY_W-1:0]  duty_nxt;
    logic [DWELL_W-1:0] dwell_cnt, dwell_nxt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               retire;

    // Readiness deliberately ignores a same-cycle pop so a full queue never
    // depends on FSM timing to accept.
    assign cmd_ready   = !fifo_full && !abort && !rst;
    assign push        = cmd_valid && cmd_ready;
    assign cmd_in.duty  = cmd_duty;
    assign cmd_in.dwell = cmd_dwell;

    pwm_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(cmd_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (abort),
        .push    (push),
        .wr_data (cmd_in),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            duty_out  <= DUTY_INIT;
            target    <= DUTY_INIT;
            dwell_cnt <= '0;
            cmd_reg   <= '0;
        end else begin
            state     <= state_nxt;
            duty_out  <= duty_nxt;
            target    <= target_nxt;
            dwell_cnt <= dwell_nxt;
            cmd_reg   <= cmd_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        duty_nxt   = duty_out;
        target_nxt = target;
        dwell_nxt  = dwell_cnt;
        cmd_nxt    = cmd_reg;
        pop        = 1'b0;
        retire     = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    cmd_nxt   = fifo_head;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                target_nxt = clamp_duty(cmd_reg.duty);
                dwell_nxt  = cmd_reg.dwell;
                state_nxt  = RAMP;
            end
            RAMP: begin
                if (period_start) begin
                    if (duty_out == target) begin
                        state_nxt = DWELL;
                    end else begin
                        // target is already clamped, so stepping toward it
                        // can never leave 0..DUTY_MAX.
                        if (duty_out < target) duty_nxt = duty_out + 1'b1;
                        else                   duty_nxt = duty_out - 1'b1;
                        if (duty_nxt == target) state_nxt = DWELL;
                    end
                end
            end
            DWELL: begin
                if (period_start) begin
                    if (dwell_cnt == '0) begin
                        retire    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        dwell_nxt = dwell_cnt - 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Abort overrides everything decided above, including a duty step.
        if (abort) begin
            state_nxt = IDLE;
            duty_nxt  = duty_out;
            dwell_nxt = '0;
            pop       = 1'b0;
            retire    = 1'b0;
        end
    end

    assign done      = retire && !rst;
    assign clamp_err = (state == LOAD) && (cmd_reg.duty > DUTY_MAX) && !abort && !rst;
    assign busy      = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
module tb_pwm_duty_sequencer;
    import pwm_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [DUTY_W-1:0]  cmd_duty;
    logic [DWELL_W-1:0] cmd_dwell;
    logic               period_start;
    logic               abort;
    logic [DUTY_W-1:0]  duty_out;
    logic               busy;
    logic               done;
    logic               clamp_err;

    pwm_duty_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_duty     (cmd_duty),
        .cmd_dwell    (cmd_dwell),
        .period_start (period_start),
        .abort        (abort),
        .duty_out     (duty_out),
        .busy         (busy),
        .done         (done),
        .clamp_err    (clamp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] duty;
        bit          clamp;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   pcnt  = 0;
    int   n_done = 0;
    bit   last_ps = 0;
    bit   clamp_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock: period_start is pulsed every 10th cycle; combinational
    // outputs are sampled mid-cycle, registered ones 1ns after the edge.
    task automatic step();
        exp_t e;
        period_start = (pcnt == 9);
        #2;
        if (clamp_err === 1'b1) clamp_seen = 1;
        if (done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                chk("done_unexpected", done, 0);
            end else begin
                e = exp_q.pop_front();
                chk("done_duty", duty_out, e.duty);
                chk("done_clamp", clamp_seen, e.clamp);
                clamp_seen = 0;
            end
        end
        @(posedge clk);
        #1;
        last_ps = period_start;
        pcnt = (pcnt + 1) % 10;
        if (last_ps) chk("duty_range", (duty_out <= 4'd10), 1);
    endtask

    task automatic wait_boundary();
        int k = 0;
        do begin
            step();
            k++;
        end while (!last_ps && k < 20);
    endtask

    task automatic push_cmd(input int d, input int w, input bit track);
        exp_t e;
        cmd_valid = 1'b1;
        cmd_duty  = d[DUTY_W-1:0];
        cmd_dwell = w[DWELL_W-1:0];
        #1;
        chk("push_ready", cmd_ready, 1);
        if (track) begin
            e.duty  = (d > 10) ? 10 : d;
            e.clamp = (d > 10);
            exp_q.push_back(e);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int d0;
        int k;
        exp_t e;

        rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0; period_start = 1'b0;
        cmd_duty = '0; cmd_dwell = '0;
        #1;
        chk("rst_ready_low", cmd_ready, 0);
        step();
        step();
        rst = 1'b0;
        pcnt = 0;
        #1;
        chk("rst_duty", duty_out, 5);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_clamp", clamp_err, 0);
        chk("rst_ready", cmd_ready, 1);

        // Ramp 5 -> 8, dwell 2
        d0 = n_done;
        push_cmd(8, 2, 1);
        wait_boundary(); chk("t1_b1", duty_out, 6);
        wait_boundary(); chk("t1_b2", duty_out, 7);
        wait_boundary(); chk("t1_b3", duty_out, 8);
        wait_boundary();
        wait_boundary();
        chk("t1_no_early_done", n_done - d0, 0);
        chk("t1_busy", busy, 1);
        wait_boundary();
        chk("t1_done", n_done - d0, 1);
        chk("t1_busy_after", busy, 0);
        chk("t1_hold", duty_out, 8);

        // Back to 5 then target equal to current duty
        push_cmd(5, 0, 1);
        repeat (4) wait_boundary();
        chk("t2_pre", duty_out, 5);
        d0 = n_done;
        push_cmd(5, 0, 1);
        wait_boundary();
        chk("t2_b1_duty", duty_out, 5);
        chk("t2_b1_nodone", n_done - d0, 0);
        wait_boundary();
        chk("t2_b2_done", n_done - d0, 1);

        // Clamp to DUTY_MAX, then ramp all the way down
        clamp_seen = 0;
        push_cmd(13, 0, 1);
        step();
        chk("t3_clamp_load", clamp_err, 1);
        for (int i = 1; i <= 5; i++) begin
            wait_boundary();
            chk("t3_up", duty_out, 5 + i);
        end
        d0 = n_done;
        wait_boundary();
        chk("t3_up_done", n_done - d0, 1);
        chk("t3_top", duty_out, 10);
        push_cmd(0, 0, 1);
        for (int i = 1; i <= 10; i++) begin
            wait_boundary();
            chk("t3_down", duty_out, 10 - i);
        end
        d0 = n_done;
        wait_boundary();
        chk("t3_down_done", n_done - d0, 1);
        wait_boundary();
        chk("t3_floor", duty_out, 0);

        // Queue fill while a blocker command runs
        push_cmd(0, 1, 1);
        step();
        push_cmd(2, 0, 1);
        push_cmd(1, 0, 1);
        push_cmd(3, 1, 1);
        push_cmd(4, 0, 1);
        chk("t4_full_ready", cmd_ready, 0);
        cmd_valid = 1'b1; cmd_duty = 4'd6; cmd_dwell = 8'd0;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 300) begin
            step();
            k++;
        end
        chk("t4_held", (k > 0), 1);
        chk("t4_accept", cmd_ready, 1);
        e.duty = 6; e.clamp = 0;
        exp_q.push_back(e);
        step();
        cmd_valid = 1'b0;
        k = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && k < 2000) begin
            step();
            k++;
        end
        chk("t4_drain", exp_q.size(), 0);
        chk("t4_idle", busy, 0);
        chk("t4_final", duty_out, 6);

        // Abort mid-ramp colliding with period_start and a push
        push_cmd(10, 0, 1);
        wait_boundary();
        chk("t5_b1", duty_out, 7);
        push_cmd(3, 0, 0);
        push_cmd(2, 0, 0);
        k = 0;
        while (pcnt != 9 && k < 20) begin
            step();
            k++;
        end
        abort = 1'b1; cmd_valid = 1'b1; cmd_duty = 4'd1; cmd_dwell = 8'd0;
        #1;
        chk("t5_abort_ready", cmd_ready, 0);
        d0 = n_done;
        step();
        abort = 1'b0; cmd_valid = 1'b0;
        exp_q.delete();
        chk("t5_abort_edge", last_ps, 1);
        chk("t5_duty_held", duty_out, 7);
        chk("t5_busy", busy, 0);
        chk("t5_nodone", n_done - d0, 0);
        wait_boundary();
        wait_boundary();
        chk("t5_still_duty", duty_out, 7);
        chk("t5_still_idle", busy, 0);
        chk("t5_still_nodone", n_done - d0, 0);

        // Synchronous reset mid-ramp
        push_cmd(0, 0, 1);
        wait_boundary();
        chk("t6_b1", duty_out, 6);
        step();
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", cmd_ready, 0);
        step();
        rst = 1'b0;
        exp_q.delete();
        clamp_seen = 0;
        #1;
        chk("t6_duty", duty_out, 5);
        chk("t6_busy", busy, 0);
        chk("t6_ready", cmd_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_duty_sequencer.md
Name: pwm_duty_sequencer

Overview:
- Command-driven controller that sequences the duty-cycle input of the PWM datapath (period of DUTY_MAX counts, duty in 0..DUTY_MAX).
- Queues commands of the form (target duty, dwell periods) and ramps duty by ±1 per PWM period boundary until the target is reached.
- Holds the target for the dwell count, then retires the command.
- Replaces direct button inc/dec of the duty register. duty_out changes only at period boundaries, so no glitched PWM periods occur.

Parameters:
- DUTY_W, 4, width of duty values.
- DUTY_MAX, 10, PWM period length in counts; maximum legal duty.
- DUTY_INIT, 5, duty_out value after reset (50%).
- DWELL_W, 8, width of the dwell count.
- FIFO_DEPTH, 4, command queue entries (power of two).

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  queue can accept; equals !full && !abort && !rst.
- cmd_duty  input  DUTY_W  target duty.
- cmd_dwell  input  DWELL_W  periods to hold at target.
- period_start  input  1  one-cycle pulse from the PWM counter wrap (counter 9→0).
- abort  input  1  flush queue, stop sequencing.
- duty_out  output  DUTY_W  duty value to the PWM comparator.
- busy  output  1  high when state != IDLE or queue is non-empty.
- done  output  1  one-cycle pulse when a command retires.
- clamp_err  output  1  one-cycle pulse when a loaded cmd_duty > DUTY_MAX.

Behaviour:
- Reset (rst=1 at posedge): duty_out=DUTY_INIT, queue empty, state=IDLE, busy=0, done=0, clamp_err=0. cmd_ready=0 while rst is high.
- Push: when cmd_valid && cmd_ready, {cmd_duty, cmd_dwell} is written to the queue.
  - cmd_ready ignores a same-cycle pop: a full queue refuses the push even if it is popping.
- FSM states: IDLE, LOAD, RAMP, DWELL.
- IDLE: if the queue is non-empty, pop and go to LOAD next cycle. Otherwise stay.
- LOAD (1 cycle):
  - target = min(head.duty, DUTY_MAX); dwell_cnt = head.dwell.
  - clamp_err pulses this cycle if head.duty > DUTY_MAX.
  - Next state RAMP.
- RAMP: act only on cycles with period_start=1.
  - If duty_out == target: go to DWELL.
  - Else duty_out steps ±1 toward target. If the new value == target, go to DWELL on the same edge.
  - Without period_start: hold.
- DWELL: act only on cycles with period_start=1.
  - If dwell_cnt == 0: pulse done, go to IDLE.
  - Else dwell_cnt -= 1.
- Latency from push to first duty change: ≥3 cycles (push, IDLE pop, LOAD), then the next period_start.
- duty_out updates only on a clk edge where period_start=1. Never updates otherwise, including during LOAD and abort.
- abort (any state): queue flushed, state=IDLE, dwell_cnt cleared, duty_out held at its current value, no done pulse.
  - If a push, period_start, or done condition occurs in the same cycle, abort wins: the push is not accepted and the duty step is not taken.
- rst mid-ramp: identical to power-on reset; duty_out returns to DUTY_INIT immediately.
- Arithmetic: duty_out never leaves 0..DUTY_MAX. No wrap at 0 or at DUTY_MAX. dwell_cnt never underflows.
- Back-to-back commands: after done, IDLE pops the next entry on the following cycle. There are no idle periods beyond FSM cycles.

Decomposition:
- Shared package pwm_pkg:
  - DUTY_W, DUTY_MAX, DUTY_INIT constants.
  - State enum {IDLE, LOAD, RAMP, DWELL}.
  - Command struct {duty, dwell}, shared with the PWM datapath and the top level.
- One sub-module: pwm_cmd_fifo.
  - Synchronous FIFO, FIFO_DEPTH entries, push/pop/full/empty, synchronous active-high reset, flush input driven by abort.
- FSM, ramp and dwell logic stay in pwm_duty_sequencer.

Test Plan:
- Reset, then period_start every 10 clks, push (duty=8, dwell=2):
  - duty_out = 6, 7, 8 at boundaries 1–3 (DWELL entered at boundary 3).
  - done pulses at boundary 6; busy falls the cycle after.
- Push (duty=5, dwell=0) from reset: duty unchanged, DWELL entered at boundary 1, done at boundary 2.
- Push (duty=13, dwell=0) from duty 5:
  - clamp_err pulses in LOAD.
  - duty ramps 6..10 and never exceeds 10.
  - Then push (duty=0, dwell=0): ramps down to 0 with no underflow.
- Push 5 commands back-to-back with no pops possible: cmd_ready=0 after the 4th accept, the 5th is held until the first pop; all 4 queued commands execute in order.
- Mid-ramp (duty=7, target 10): assert abort together with period_start and cmd_valid → duty_out stays 7, queue empty, no done pulse, push not accepted.
- Mid-ramp: assert rst for 1 cycle → next cycle duty_out=5, busy=0, cmd_ready=1.
